// File: rtl/player2_spi_pkg.sv
// Shared types and constants for the Player 2 SPI status transmitter.
package player2_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } tx_state_t;

  localparam int          SPI_FRAME_BITS = 8;
  localparam int          BIT_CNT_W      = $clog2(SPI_FRAME_BITS);
  localparam logic [7:0]  IDLE_BYTE      = 8'h00;

endpackage

// File: rtl/spi_edge_sync.sv
// Edge detector for an asynchronous SPI input (spi_clk or spi_cs).
// Build option PLAYER2_TX_SYNC_EN: when defined, the input first passes a
// 2-flop synchronizer (input-to-edge latency 3 clk); otherwise the raw input
// is compared against one edge-detect register (latency 1 clk).
// All registers clear to 0 so a reset taken while CS is low cannot manufacture
// a falling edge; a fresh CS fall is needed to start the next frame.
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic level;
  logic prev_reg;

`ifdef PLAYER2_TX_SYNC_EN
  logic [1:0] sync_reg;

  // Two-stage metastability synchronizer.
  always_ff @(posedge clk) begin
    if (!rst) sync_reg <= 2'b00;
    else      sync_reg <= {sync_reg[0], din};
  end

  assign level = sync_reg[1];
`else
  assign level = din;
`endif

  // Previous-sample register used for rise/fall pulse generation.
  always_ff @(posedge clk) begin
    if (!rst) prev_reg <= 1'b0;
    else      prev_reg <= level;
  end

  assign rise = level & ~prev_reg;
  assign fall = ~level & prev_reg;

endmodule

// File: rtl/player2_status_tx.sv
// SPI mode-0 slave transmitter: ships one status byte per chip-select frame,
// MSB first, from a one-deep valid/ready holding register.
// Build option PLAYER2_TX_SYNC_EN selects 2-flop input synchronizers inside
// spi_edge_sync; default build uses a single edge-detect register.
module player2_status_tx
  import player2_spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort,
  output logic       busy
);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  spi_edge_sync u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_clk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_edge_sync u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (spi_cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  tx_state_t              state_reg;
  logic [7:0]             hold_reg;
  logic                   hold_full_reg;
  logic [7:0]             shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic                   oe_reg;
  logic                   done_reg;
  logic                   abort_reg;

  logic accept;
  assign accept = tx_valid && !hold_full_reg;

  // Frame FSM, holding register, shifter and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
      shift_reg     <= 8'h00;
      bit_cnt_reg   <= '0;
      oe_reg        <= 1'b0;
      done_reg      <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      abort_reg <= 1'b0;

      // Output enable tracks the synchronized CS level through its edges.
      if (cs_fall)      oe_reg <= 1'b1;
      else if (cs_rise) oe_reg <= 1'b0;

      // A write landing on the load cycle of an empty hold is kept for the
      // next frame; the current frame still sends the idle byte.
      if (accept) begin
        hold_reg      <= tx_data;
        hold_full_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg   <= SHIFT;
            bit_cnt_reg <= '0;
            if (hold_full_reg) begin
              shift_reg     <= hold_reg;
              hold_full_reg <= 1'b0;
            end else begin
              shift_reg <= IDLE_BYTE;
            end
          end
        end
        SHIFT: begin
          // CS release wins over any SCLK edge seen on the same cycle.
          if (cs_rise) begin
            abort_reg <= 1'b1;
            state_reg <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_CNT_W'(SPI_FRAME_BITS - 1)) begin
              done_reg  <= 1'b1;
              state_reg <= WAIT;
            end
          end else if (sclk_fall) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
          end
        end
        WAIT: begin
          if (cs_rise) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_miso = (state_reg == SHIFT) ? shift_reg[7] : 1'b0;
  assign miso_oe  = oe_reg;
  assign tx_ready = !hold_full_reg;
  assign tx_done  = done_reg;
  assign tx_abort = abort_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_player2_status_tx.sv
// Self-checking bench for player2_status_tx: directed vector table from the
// test plan, randomized frames against a byte-level reference model, and a
// hand-written mid-frame reset sequence.
module tb_player2_status_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_cs;
  logic       spi_miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_abort;
  logic       busy;

  player2_status_tx dut (
    .clk      (clk),
    .rst      (rst),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_miso (spi_miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_done  (tx_done),
    .tx_abort (tx_abort),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (tx_done)  done_cnt  <= done_cnt + 1;
    if (tx_abort) abort_cnt <= abort_cnt + 1;
  end

  // Reference model: one-deep mailbox of posted bytes.
  logic       model_full;
  logic [7:0] model_hold;

  typedef struct {
    logic       post;
    logic [7:0] data;
    logic       post2;
    logic [7:0] data2;
    int         nrise;
    logic [7:0] exp_byte;
    int         exp_done;
    int         exp_abort;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic post(input logic [7:0] d);
    check("ready_before_post", {31'd0, tx_ready}, {31'd0, !model_full});
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      model_hold = d;
    end
    check("ready_after_post", {31'd0, tx_ready}, 32'd0);
  endtask

  function automatic logic [7:0] rise_mask(input int nrise);
    logic [7:0] ones;
    ones = 8'hFF;
    if (nrise >= 8) return ones;
    return ~(ones >> nrise);
  endfunction

  // Arduino-side master: CS low, nrise SCLK periods sampling MISO on each
  // rising edge, then CS high.
  task automatic run_frame(input int nrise, output logic [7:0] got, output logic extra_hi,
                           output int dn, output int ab, output logic busy_seen,
                           output logic oe_seen);
    int d0, a0;
    d0 = done_cnt;
    a0 = abort_cnt;
    got = 8'h00;
    extra_hi = 1'b0;
    spi_cs = 1'b0;
    tick(8);
    busy_seen = busy;
    oe_seen   = miso_oe;
    for (int i = 0; i < nrise; i++) begin
      if (i < 8) got[7-i] = spi_miso;
      else       extra_hi = extra_hi | spi_miso;
      spi_clk = 1'b1;
      tick(8);
      spi_clk = 1'b0;
      tick(8);
    end
    spi_cs = 1'b1;
    tick(8);
    dn = done_cnt - d0;
    ab = abort_cnt - a0;
  endtask

  task automatic frame_and_check(input string tag, input int nrise, input logic [7:0] exp_byte,
                                 input int exp_done, input int exp_abort, input logic exp_ready);
    logic [7:0] got, m;
    logic       extra_hi, busy_seen, oe_seen;
    int         dn, ab;
    run_frame(nrise, got, extra_hi, dn, ab, busy_seen, oe_seen);
    m = rise_mask(nrise);
    check({tag, "_miso_bits"}, {24'd0, got & m}, {24'd0, exp_byte & m});
    check({tag, "_done_pulses"}, dn, exp_done);
    check({tag, "_abort_pulses"}, ab, exp_abort);
    check({tag, "_miso_after_8"}, {31'd0, extra_hi}, 32'd0);
    check({tag, "_busy_in_frame"}, {31'd0, busy_seen}, 32'd1);
    check({tag, "_oe_in_frame"}, {31'd0, oe_seen}, 32'd1);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_oe_after"}, {31'd0, miso_oe}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, tx_ready}, {31'd0, exp_ready});
    $display("%s: nrise=%0d got=%02h exp=%02h done=%0d abort=%0d ready=%0b",
             tag, nrise, got & m, exp_byte & m, dn, ab, tx_ready);
  endtask

  initial begin
    logic [7:0] exp_byte, d;
    logic       bad_seen;
    int         nrise, d0, a0;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 8,  8'hA5, 1, 0, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 8'h00, 8,  8'h00, 1, 0, 1'b1};
    vecs[2] = '{1'b1, 8'h3C, 1'b0, 8'h00, 3,  8'h3C, 0, 1, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 8,  8'h00, 1, 0, 1'b1};
    vecs[4] = '{1'b1, 8'h81, 1'b1, 8'h7E, 8,  8'h81, 1, 0, 1'b1};
    vecs[5] = '{1'b1, 8'hFF, 1'b0, 8'h00, 10, 8'hFF, 1, 0, 1'b1};

    model_full = 1'b0;
    model_hold = 8'h00;
    rst      = 1'b0;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(4);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_abort", {31'd0, tx_abort}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    tick(8);

    // Directed vectors from the test plan.
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].post)  post(vecs[v].data);
      if (vecs[v].post2) post(vecs[v].data2);
      model_full = 1'b0;
      frame_and_check($sformatf("vec%0d", v), vecs[v].nrise, vecs[v].exp_byte,
                      vecs[v].exp_done, vecs[v].exp_abort, vecs[v].exp_ready);
    end

    // Randomized frames against the mailbox model.
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 1) == 1) post(8'($urandom));
      if ($urandom_range(0, 3) == 0) post(8'($urandom));
      nrise = $urandom_range(0, 11);
      exp_byte = model_full ? model_hold : 8'h00;
      model_full = 1'b0;
      frame_and_check($sformatf("rnd%0d", r), nrise, exp_byte,
                      (nrise >= 8) ? 1 : 0, (nrise >= 8) ? 0 : 1, 1'b1);
    end

    // Reset asserted for one cycle during bit 4 of a frame.
    d = 8'h55;
    post(d);
    d0 = done_cnt;
    a0 = abort_cnt;
    spi_cs = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      spi_clk = 1'b1; tick(8);
      spi_clk = 1'b0; tick(8);
    end
    rst = 1'b0;
    tick(1);
    check("midrst_miso", {31'd0, spi_miso}, 32'd0);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd1);
    check("midrst_done", {31'd0, tx_done}, 32'd0);
    check("midrst_abort", {31'd0, tx_abort}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    bad_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bad_seen = bad_seen | busy | spi_miso;
      spi_clk = 1'b1; tick(8);
      bad_seen = bad_seen | busy | spi_miso;
      spi_clk = 1'b0; tick(8);
    end
    spi_cs = 1'b1;
    tick(8);
    check("postrst_sclk_ignored", {31'd0, bad_seen}, 32'd0);
    check("postrst_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    $display("midrst: reset during bit 4, busy_or_miso_seen=%0b", bad_seen);
    model_full = 1'b0;
    frame_and_check("afterrst", 8, 8'h00, 1, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
